// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter: shares the single-port program memory between the CPU
// instruction-fetch path (F) and the host program loader (L). It runs one memory
// transaction at a time through IDLE -> ISSUE -> WAIT. All outputs are registered.
//
// Build option: define ARB_FIXED_PRIO_EN for fixed priority with L over F.
// When it is undefined, arbitration is round-robin and F wins the first tie.
`timescale 1ns/1ps
module imem_port_arbiter #(
   parameter int unsigned AW     = 8,
   parameter int unsigned DW     = 8,
   parameter int unsigned RD_LAT = 1
) (
   input  logic          clk,
   input  logic          CLB,
   input  logic          f_req,
   input  logic [AW-1:0] f_addr,
   output logic          f_gnt,
   output logic          f_valid,
   output logic [DW-1:0] f_rdata,
   input  logic          l_req,
   input  logic          l_we,
   input  logic [AW-1:0] l_addr,
   input  logic [DW-1:0] l_wdata,
   output logic          l_gnt,
   output logic          l_valid,
   output logic [DW-1:0] l_rdata,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy
);

   if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
      $error("imem_port_arbiter: RD_LAT must be in 1..4");
   end

   typedef enum logic [1:0] {StIdle = 2'd0, StIssue = 2'd1, StWait = 2'd2} state_e;

   state_e        state_q, state_d;
   logic          win_l_q, win_l_d;    // owner of the current transaction (1 = loader)
   logic          op_we_q, op_we_d;    // current transaction is a write
   logic [2:0]    cnt_q, cnt_d;        // remaining read-latency cycles
   logic          pick_l;

   logic          mem_en_q, mem_en_d;
   logic          mem_we_q, mem_we_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic [DW-1:0] mem_wdata_q, mem_wdata_d;
   logic          f_gnt_q, f_gnt_d;
   logic          l_gnt_q, l_gnt_d;
   logic          f_valid_q, f_valid_d;
   logic          l_valid_q, l_valid_d;
   logic [DW-1:0] f_rdata_q, f_rdata_d;
   logic [DW-1:0] l_rdata_q, l_rdata_d;
   logic          busy_q, busy_d;

`ifndef ARB_FIXED_PRIO_EN
   logic          prio_l_q, prio_l_d;  // 1 = loader wins the next tie
`endif

   // Winner selection among the current requesters.
   always_comb begin
`ifdef ARB_FIXED_PRIO_EN
      pick_l = l_req;
`else
      pick_l = l_req && (!f_req || prio_l_q);
`endif
   end

   // Next-state and registered-output logic.
   always_comb begin
      state_d     = state_q;
      win_l_d     = win_l_q;
      op_we_d     = op_we_q;
      cnt_d       = cnt_q;
      mem_en_d    = 1'b0;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      f_gnt_d     = 1'b0;
      l_gnt_d     = 1'b0;
      f_valid_d   = 1'b0;
      l_valid_d   = 1'b0;
      f_rdata_d   = f_rdata_q;
      l_rdata_d   = l_rdata_q;
`ifndef ARB_FIXED_PRIO_EN
      prio_l_d    = prio_l_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (f_req || l_req) begin
               win_l_d    = pick_l;
               op_we_d    = pick_l && l_we;
               mem_en_d   = 1'b1;
               mem_we_d   = pick_l && l_we;
               mem_addr_d = pick_l ? l_addr : f_addr;
               // Fetches never write, so the write-data bus keeps its last value.
               if (pick_l) begin
                  mem_wdata_d = l_wdata;
               end
               f_gnt_d    = !pick_l;
               l_gnt_d    = pick_l;
`ifndef ARB_FIXED_PRIO_EN
               prio_l_d   = !pick_l;
`endif
               state_d    = StIssue;
            end
         end
         StIssue: begin
            cnt_d   = 3'(RD_LAT);
            state_d = StWait;
         end
         StWait: begin
            cnt_d = cnt_q - 3'd1;
            // cnt_q == 1 is the cycle in which mem_rdata is valid.
            if (cnt_q == 3'd1) begin
               if (!op_we_q) begin
                  if (win_l_q) begin
                     l_rdata_d = mem_rdata;
                  end else begin
                     f_rdata_d = mem_rdata;
                  end
               end
               f_valid_d = !win_l_q;
               l_valid_d = win_l_q;
               state_d   = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
      busy_d = (state_d != StIdle);
   end

   // State and output registers; reset drops any in-flight transaction.
   always_ff @(posedge clk or negedge CLB) begin
      if (!CLB) begin
         state_q     <= StIdle;
         win_l_q     <= 1'b0;
         op_we_q     <= 1'b0;
         cnt_q       <= 3'd0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         f_gnt_q     <= 1'b0;
         l_gnt_q     <= 1'b0;
         f_valid_q   <= 1'b0;
         l_valid_q   <= 1'b0;
         f_rdata_q   <= '0;
         l_rdata_q   <= '0;
         busy_q      <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
         prio_l_q    <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         win_l_q     <= win_l_d;
         op_we_q     <= op_we_d;
         cnt_q       <= cnt_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         f_gnt_q     <= f_gnt_d;
         l_gnt_q     <= l_gnt_d;
         f_valid_q   <= f_valid_d;
         l_valid_q   <= l_valid_d;
         f_rdata_q   <= f_rdata_d;
         l_rdata_q   <= l_rdata_d;
         busy_q      <= busy_d;
`ifndef ARB_FIXED_PRIO_EN
         prio_l_q    <= prio_l_d;
`endif
      end
   end

   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign f_gnt     = f_gnt_q;
   assign l_gnt     = l_gnt_q;
   assign f_valid   = f_valid_q;
   assign l_valid   = l_valid_q;
   assign f_rdata   = f_rdata_q;
   assign l_rdata   = l_rdata_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Bench for imem_port_arbiter: three instances (RD_LAT = 1, 3, 4) share one
// stimulus. Each has its own memory and its own transaction-level model. The
// model is checked on every cycle, and directed literal checks pin the model.
`timescale 1ns/1ps
module tb_imem_port_arbiter;
   localparam int N = 3;

   logic       clk;
   logic       CLB;
   logic       f_req;
   logic [7:0] f_addr;
   logic       l_req;
   logic       l_we;
   logic [7:0] l_addr;
   logic [7:0] l_wdata;

   logic [N-1:0] f_gnt_w, f_valid_w, l_gnt_w, l_valid_w, mem_en_w, mem_we_w, busy_w;
   logic [7:0]   f_rdata_w [N];
   logic [7:0]   l_rdata_w [N];
   logic [7:0]   mem_addr_w [N];
   logic [7:0]   mem_wdata_w [N];

   int tests_run    = 0;
   int tests_failed = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar g = 0; g < N; g++) begin : g_inst
      localparam int unsigned LAT = (g == 0) ? 1 : ((g == 1) ? 3 : 4);
      logic [7:0] mem [256];
      logic [7:0] pipe [4];
      logic       fg, fv, lg, lv, me, mw, bz;
      logic [7:0] frd, lrd, ma, mwd;

      imem_port_arbiter #(.AW(8), .DW(8), .RD_LAT(LAT)) u_dut (
         .clk(clk), .CLB(CLB),
         .f_req(f_req), .f_addr(f_addr), .f_gnt(fg), .f_valid(fv), .f_rdata(frd),
         .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
         .l_gnt(lg), .l_valid(lv), .l_rdata(lrd),
         .mem_en(me), .mem_we(mw), .mem_addr(ma), .mem_wdata(mwd),
         .mem_rdata(pipe[LAT-1]), .busy(bz)
      );

      assign f_gnt_w[g]     = fg;
      assign f_valid_w[g]   = fv;
      assign l_gnt_w[g]     = lg;
      assign l_valid_w[g]   = lv;
      assign mem_en_w[g]    = me;
      assign mem_we_w[g]    = mw;
      assign busy_w[g]      = bz;
      assign f_rdata_w[g]   = frd;
      assign l_rdata_w[g]   = lrd;
      assign mem_addr_w[g]  = ma;
      assign mem_wdata_w[g] = mwd;

      initial for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h39;

      // Memory macro: read data appears LAT cycles after the mem_en cycle.
      always @(posedge clk) begin
         if (me && mw) mem[ma] <= mwd;
         pipe[0] <= (me && !mw) ? mem[ma] : 8'hEE;
         for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
      end
   end

   // Transaction model: edge numbers at which each event is due.
   int         lat_of [N] = '{1, 3, 4};
   int         m_e [N];
   int         m_gnt [N];
   int         m_val [N];
   int         m_free [N];
   bit         m_win_l [N];
   bit         m_prio_l [N];
   bit         m_we [N];
   logic [7:0] m_addr [N];
   logic [7:0] m_wd [N];
   logic [7:0] m_frd [N];
   logic [7:0] m_lrd [N];
   logic [7:0] m_mem [N][256];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic model_reset(input int i);
      m_e[i] = 0; m_gnt[i] = -100; m_val[i] = -100; m_free[i] = 0;
      m_win_l[i] = 0; m_prio_l[i] = 0; m_we[i] = 0;
      m_addr[i] = 8'h00; m_wd[i] = 8'h00; m_frd[i] = 8'h00; m_lrd[i] = 8'h00;
   endtask

   task automatic model_edge(input int i);
      bit w;
      if (!CLB) begin
         model_reset(i);
         return;
      end
      m_e[i]++;
      if (m_e[i] == m_gnt[i] + 1 && m_we[i]) m_mem[i][m_addr[i]] = m_wd[i];
      if (m_e[i] == m_val[i] && !m_we[i]) begin
         if (m_win_l[i]) m_lrd[i] = m_mem[i][m_addr[i]];
         else m_frd[i] = m_mem[i][m_addr[i]];
      end
      if (m_e[i] >= m_free[i] && (f_req || l_req)) begin
         if (f_req && l_req) begin
`ifdef ARB_FIXED_PRIO_EN
            w = 1'b1;
`else
            w = m_prio_l[i];
`endif
         end else begin
            w = l_req;
         end
         m_prio_l[i] = !w;
         m_win_l[i]  = w;
         m_addr[i]   = w ? l_addr : f_addr;
         m_we[i]     = w && l_we;
         if (w) m_wd[i] = l_wdata;
         m_gnt[i]  = m_e[i];
         m_val[i]  = m_e[i] + lat_of[i] + 1;
         m_free[i] = m_e[i] + lat_of[i] + 2;
      end
   endtask

   function automatic logic [38:0] model_out(input int i);
      bit issue;
      bit done;
      issue = (m_e[i] == m_gnt[i]);
      done  = (m_e[i] == m_val[i]);
      return {(m_e[i] >= m_gnt[i] && m_e[i] < m_val[i]), issue, issue && m_we[i],
              m_addr[i], m_wd[i], issue && !m_win_l[i], done && !m_win_l[i], m_frd[i],
              issue && m_win_l[i], done && m_win_l[i], m_lrd[i]};
   endfunction

   function automatic logic [38:0] dut_out(input int i);
      return {busy_w[i], mem_en_w[i], mem_we_w[i], mem_addr_w[i], mem_wdata_w[i],
              f_gnt_w[i], f_valid_w[i], f_rdata_w[i], l_gnt_w[i], l_valid_w[i], l_rdata_w[i]};
   endfunction

   // One clock: advance the models at the edge, compare every instance at the falling edge.
   task automatic tick();
      @(posedge clk);
      for (int i = 0; i < N; i++) model_edge(i);
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         if (!CLB) model_reset(i);
         chk($sformatf("cycle_lat%0d", lat_of[i]), 64'(dut_out(i)), 64'(model_out(i)));
      end
   endtask

   task automatic settle(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   initial begin
      logic [3:0] seq;
      int         n;
      int         tk [4];
      int         lv_cyc;
      int         fg_cyc;
      int         fv_cyc;

      CLB = 1'b0; f_req = 1'b0; f_addr = 8'h00;
      l_req = 1'b0; l_we = 1'b0; l_addr = 8'h00; l_wdata = 8'h00;
      for (int i = 0; i < N; i++) begin
         model_reset(i);
         for (int j = 0; j < 256; j++) m_mem[i][j] = 8'(j) ^ 8'h39;
      end

      // Reset state
      settle(2);
      chk("rst_busy", 64'(busy_w), 64'd0);
      chk("rst_mem_en", 64'(mem_en_w), 64'd0);
      chk("rst_f_rdata", 64'(f_rdata_w[0]), 64'd0);
      CLB = 1'b1;

      // Single fetch of 0x05 (memory holds 0x3C)
      f_req = 1'b1; f_addr = 8'h05;
      tick();
      chk("t1_mem_en_c1", 64'(mem_en_w[0]), 64'd1);
      chk("t1_f_gnt_c1", 64'(f_gnt_w[0]), 64'd1);
      chk("t1_busy_c1", 64'(busy_w[0]), 64'd1);
      f_req = 1'b0;
      tick();
      chk("t1_busy_c2", 64'(busy_w[0]), 64'd1);
      chk("t1_f_valid_c2", 64'(f_valid_w[0]), 64'd0);
      tick();
      chk("t1_f_valid_c3", 64'(f_valid_w[0]), 64'd1);
      chk("t1_f_rdata_c3", 64'(f_rdata_w[0]), 64'h3C);
      chk("t1_busy_c3", 64'(busy_w[0]), 64'd0);
      settle(6);

      // Loader write 0xA5 to 0x10, then read it back
      l_req = 1'b1; l_we = 1'b1; l_addr = 8'h10; l_wdata = 8'hA5;
      tick();
      chk("t2_wr_mem_we", 64'(mem_we_w[0]), 64'd1);
      chk("t2_wr_l_gnt", 64'(l_gnt_w[0]), 64'd1);
      l_req = 1'b0;
      tick();
      chk("t2_wr_mem_we_wait", 64'(mem_we_w[0]), 64'd0);
      tick();
      chk("t2_wr_l_valid", 64'(l_valid_w[0]), 64'd1);
      settle(6);
      l_req = 1'b1; l_we = 1'b0;
      tick();
      chk("t2_rd_l_gnt", 64'(l_gnt_w[0]), 64'd1);
      chk("t2_rd_mem_we", 64'(mem_we_w[0]), 64'd0);
      l_req = 1'b0;
      settle(2);
      chk("t2_rd_l_valid", 64'(l_valid_w[0]), 64'd1);
      chk("t2_rd_l_rdata", 64'(l_rdata_w[0]), 64'hA5);
      settle(6);

      // Both requesters held for 12 cycles straight after reset
      CLB = 1'b0;
      tick();
      CLB = 1'b1;
      f_req = 1'b1; f_addr = 8'h05; l_req = 1'b1; l_we = 1'b0; l_addr = 8'h10;
      seq = 4'b0000; n = 0;
      for (int k = 1; k <= 12; k++) begin
         tick();
         if ((f_gnt_w[0] || l_gnt_w[0]) && n < 4) begin
            seq[n] = l_gnt_w[0];
            tk[n]  = k;
            n++;
         end
      end
      f_req = 1'b0; l_req = 1'b0;
      chk("t3_grant_count", 64'(n), 64'd4);
      chk("t3_first_grant_cycle", 64'(tk[0]), 64'd1);
      chk("t3_grant_spacing", 64'(tk[1] - tk[0]), 64'd3);
`ifdef ARB_FIXED_PRIO_EN
      chk("t3_fixed_order_LLLL", 64'(seq), 64'b1111);
`else
      chk("t3_rr_order_FLFL", 64'(seq), 64'b1010);
`endif
      settle(8);

      // Reset during WAIT (RD_LAT=3 instance)
      f_req = 1'b1; f_addr = 8'h22;
      tick();
      f_req = 1'b0;
      settle(2);
      chk("t4_busy_before_rst", 64'(busy_w[1]), 64'd1);
      CLB = 1'b0;
      #1;
      chk("t4_busy_in_rst", 64'(busy_w[1]), 64'd0);
      chk("t4_mem_addr_in_rst", 64'(mem_addr_w[1]), 64'd0);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("t4_no_f_valid", 64'(f_valid_w[1]), 64'd0);
      end
      CLB = 1'b1;
      l_req = 1'b1; l_we = 1'b0; l_addr = 8'h10;
      tick();
      chk("t4_post_rst_l_gnt", 64'(l_gnt_w[1]), 64'd1);
      l_req = 1'b0;
      settle(4);
      chk("t4_post_rst_l_valid", 64'(l_valid_w[1]), 64'd1);
      chk("t4_post_rst_l_rdata", 64'(l_rdata_w[1]), 64'hA5);
      settle(6);

      // Fetch arrives during loader WAIT (RD_LAT=4 instance)
      l_req = 1'b1; l_we = 1'b0; l_addr = 8'h10;
      tick();
      chk("t5_l_gnt", 64'(l_gnt_w[2]), 64'd1);
      l_req = 1'b0; f_req = 1'b1; f_addr = 8'h05;
      lv_cyc = 0; fg_cyc = 0;
      for (int k = 2; k <= 14; k++) begin
         tick();
         if (l_valid_w[2]) lv_cyc = k;
         if (f_gnt_w[2]) begin
            fg_cyc = k;
            break;
         end
      end
      f_req = 1'b0;
      chk("t5_l_valid_cycle", 64'(lv_cyc), 64'd6);
      chk("t5_f_gnt_cycle", 64'(fg_cyc), 64'd7);
      fv_cyc = 0;
      for (int k = 1; k <= 10; k++) begin
         tick();
         if (f_valid_w[2]) begin
            fv_cyc = k;
            break;
         end
      end
      chk("t5_f_valid_delay", 64'(fv_cyc), 64'd5);
      chk("t5_f_rdata", 64'(f_rdata_w[2]), 64'h3C);
      chk("t5_l_rdata_kept", 64'(l_rdata_w[2]), 64'hA5);
      settle(4);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
